// File: rtl/id_ex_pipe_if.sv
// ID/EX stage bundle: decode-side fields, regfile data, writeback port and EX-side outputs.
// master drives the decode/writeback side; slave is the pipeline register.
interface id_ex_pipe_if #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [4:0]        id_ra1;
  logic [4:0]        id_ra2;
  logic [4:0]        id_wa;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_memread;
  logic [31:0]       rd1;
  logic [31:0]       rd2;
  logic              wb_we;
  logic [4:0]        wb_wa;
  logic [31:0]       wb_wd;
  logic              ext_stall;
  logic              flush;
  logic              stall_id;
  logic              ex_valid;
  logic [31:0]       ex_rd1;
  logic [31:0]       ex_rd2;
  logic [4:0]        ex_ra1;
  logic [4:0]        ex_ra2;
  logic [4:0]        ex_wa;
  logic [31:0]       ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_memread;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_ra1, id_ra2, id_wa, id_imm, id_ctrl, id_memread,
    output rd1, rd2, wb_we, wb_wa, wb_wd, ext_stall, flush,
    input  stall_id, ex_valid, ex_rd1, ex_rd2, ex_ra1, ex_ra2, ex_wa,
    input  ex_imm, ex_ctrl, ex_memread, bubble_cnt
  );

  modport slave (
    input  id_valid, id_ra1, id_ra2, id_wa, id_imm, id_ctrl, id_memread,
    input  rd1, rd2, wb_we, wb_wa, wb_wd, ext_stall, flush,
    output stall_id, ex_valid, ex_rd1, ex_rd2, ex_ra1, ex_ra2, ex_wa,
    output ex_imm, ex_ctrl, ex_memread, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, stall/flush and a saturating bubble counter.
// Define WB_BYPASS_EN to forward the writeback port into captured and held operands.
module id_ex_pipe #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input logic         clk,
  input logic         reset,
  id_ex_pipe_if.slave bus
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t      state;
  logic        hz_c;
  logic [31:0] op1_c;
  logic [31:0] op2_c;
  logic [31:0] hold1_c;
  logic [31:0] hold2_c;

  // Load in EX whose destination is read by the instruction in ID; $0 never matches.
  assign hz_c = bus.id_valid & bus.ex_valid & bus.ex_memread & (bus.ex_wa != 5'd0) &
                ((bus.ex_wa == bus.id_ra1) | (bus.ex_wa == bus.id_ra2));

  assign bus.stall_id = ~reset &
                        (((state == RUN) & hz_c & ~bus.flush) | bus.ext_stall);

`ifdef WB_BYPASS_EN
  function automatic logic wb_hit(input logic [4:0] ra);
    return bus.wb_we & (bus.wb_wa != 5'd0) & (bus.wb_wa == ra);
  endfunction

  assign op1_c   = wb_hit(bus.id_ra1) ? bus.wb_wd : bus.rd1;
  assign op2_c   = wb_hit(bus.id_ra2) ? bus.wb_wd : bus.rd2;
  // Operands held under a downstream stall track writes to their source registers.
  assign hold1_c = (bus.ex_valid & wb_hit(bus.ex_ra1)) ? bus.wb_wd : bus.ex_rd1;
  assign hold2_c = (bus.ex_valid & wb_hit(bus.ex_ra2)) ? bus.wb_wd : bus.ex_rd2;
`else
  assign op1_c   = bus.rd1;
  assign op2_c   = bus.rd2;
  assign hold1_c = bus.ex_rd1;
  assign hold2_c = bus.ex_rd2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      bus.ex_valid   <= 1'b0;
      bus.ex_memread <= 1'b0;
      bus.ex_rd1     <= 32'd0;
      bus.ex_rd2     <= 32'd0;
      bus.ex_ra1     <= 5'd0;
      bus.ex_ra2     <= 5'd0;
      bus.ex_wa      <= 5'd0;
      bus.ex_imm     <= 32'd0;
      bus.ex_ctrl    <= CTRL_W'(0);
      bus.bubble_cnt <= CNT_W'(0);
    end else if (bus.flush) begin
      state          <= RUN;
      bus.ex_valid   <= 1'b0;
      bus.ex_memread <= 1'b0;
    end else if (bus.ext_stall) begin
      bus.ex_rd1 <= hold1_c;
      bus.ex_rd2 <= hold2_c;
    end else if ((state == RUN) && hz_c) begin
      state          <= BUBBLE;
      bus.ex_valid   <= 1'b0;
      bus.ex_memread <= 1'b0;
      if (bus.bubble_cnt != {CNT_W{1'b1}})
        bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
    end else begin
      state          <= RUN;
      bus.ex_valid   <= bus.id_valid;
      bus.ex_memread <= bus.id_valid & bus.id_memread;
      bus.ex_rd1     <= op1_c;
      bus.ex_rd2     <= op2_c;
      bus.ex_ra1     <= bus.id_ra1;
      bus.ex_ra2     <= bus.id_ra2;
      bus.ex_wa      <= bus.id_wa;
      bus.ex_imm     <= bus.id_imm;
      bus.ex_ctrl    <= bus.id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the driver queues hand-computed expectations per cycle,
// a monitor checks stall_id before each edge and the EX register after it.
module tb_id_ex_pipe;

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 2;

  typedef struct {
    logic        stall;
    logic        valid;
    logic        mr;
    logic [1:0]  cnt;
    logic        chkd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] imm;
    logic [11:0] ctrl;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   checks;
  int   failures;

  id_ex_pipe_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) intf ();

  id_ex_pipe #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: stall_id sampled mid low phase, EX outputs 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_id", 32'(intf.stall_id), 32'(e.stall));
        @(posedge clk);
        #1;
        chk("ex_valid",   32'(intf.ex_valid),   32'(e.valid));
        chk("ex_memread", 32'(intf.ex_memread), 32'(e.mr));
        chk("bubble_cnt", 32'(intf.bubble_cnt), 32'(e.cnt));
        if (e.chkd) begin
          chk("ex_rd1",  intf.ex_rd1,         e.rd1);
          chk("ex_rd2",  intf.ex_rd2,         e.rd2);
          chk("ex_wa",   32'(intf.ex_wa),     32'(e.wa));
          chk("ex_ra1",  32'(intf.ex_ra1),    32'(e.ra1));
          chk("ex_ra2",  32'(intf.ex_ra2),    32'(e.ra2));
          chk("ex_imm",  intf.ex_imm,         e.imm);
          chk("ex_ctrl", 32'(intf.ex_ctrl),   32'(e.ctrl));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [4:0] wa, input logic [31:0] imm, input logic [11:0] ctrl,
                       input logic mr, input logic [31:0] r1, input logic [31:0] r2);
    intf.id_valid   = v;
    intf.id_ra1     = ra1;
    intf.id_ra2     = ra2;
    intf.id_wa      = wa;
    intf.id_imm     = imm;
    intf.id_ctrl    = ctrl;
    intf.id_memread = mr;
    intf.rd1        = r1;
    intf.rd2        = r2;
  endtask

  task automatic ctl(input logic st, input logic fl, input logic we, input logic [4:0] wwa,
                     input logic [31:0] wwd);
    intf.ext_stall = st;
    intf.flush     = fl;
    intf.wb_we     = we;
    intf.wb_wa     = wwa;
    intf.wb_wd     = wwd;
  endtask

  task automatic expect_c(input logic st, input logic v, input logic mr, input logic [1:0] cnt);
    exp_t e;
    e = '{stall: st, valid: v, mr: mr, cnt: cnt, chkd: 1'b0, rd1: '0, rd2: '0,
          wa: '0, ra1: '0, ra2: '0, imm: '0, ctrl: '0};
    q.push_back(e);
  endtask

  task automatic expect_d(input logic st, input logic v, input logic mr, input logic [1:0] cnt,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wa,
                          input logic [4:0] ra1, input logic [4:0] ra2, input logic [31:0] imm,
                          input logic [11:0] ctrl);
    exp_t e;
    e = '{stall: st, valid: v, mr: mr, cnt: cnt, chkd: 1'b1, rd1: r1, rd2: r2,
          wa: wa, ra1: ra1, ra2: ra2, imm: imm, ctrl: ctrl};
    q.push_back(e);
  endtask

  initial begin
    logic [31:0] byp_held;
    logic [31:0] byp_cap;
    logic [1:0]  cnt_tab [4];
    cnt_tab = '{2'd2, 2'd3, 2'd3, 2'd3};
    checks   = 0;
    failures = 0;
`ifdef WB_BYPASS_EN
    byp_held = 32'd152;
    byp_cap  = 32'd421;
`else
    byp_held = 32'd31;
    byp_cap  = 32'd420;
`endif
    reset = 1'b1;
    ctl(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd10, 5'd0, 5'd1, 32'd9, 12'h9, 1'b1, 32'd5, 32'd6);

    // Reset with a valid instruction and ext_stall present: everything clears, no stall.
    @(negedge clk);
    expect_d(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 12'h0);

    // Plain capture.
    @(negedge clk);
    reset = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd3, 5'd4, 5'd23, 32'h1234, 12'hABC, 1'b0, 32'd420, 32'd143);
    expect_d(1'b0, 1'b1, 1'b0, 2'd0, 32'd420, 32'd143, 5'd23, 5'd3, 5'd4, 32'h1234, 12'hABC);

    // Load to $2.
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd6, 5'd2, 32'd0, 12'h001, 1'b1, 32'd7, 32'd8);
    expect_d(1'b0, 1'b1, 1'b1, 2'd0, 32'd7, 32'd8, 5'd2, 5'd5, 5'd6, 32'd0, 12'h001);

    // Consumer of $2 on rt: stall and bubble, other fields held.
    @(negedge clk);
    drive(1'b1, 5'd9, 5'd2, 5'd11, 32'd5, 12'h002, 1'b0, 32'd100, 32'd200);
    expect_d(1'b1, 1'b0, 1'b0, 2'd1, 32'd7, 32'd8, 5'd2, 5'd5, 5'd6, 32'd0, 12'h001);

    // Same instruction again from BUBBLE: captured, no stall.
    @(negedge clk);
    expect_d(1'b0, 1'b1, 1'b0, 2'd1, 32'd100, 32'd200, 5'd11, 5'd9, 5'd2, 32'd5, 12'h002);

    // Load targeting $0.
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd1, 5'd0, 32'd0, 12'h003, 1'b1, 32'd11, 32'd12);
    expect_c(1'b0, 1'b1, 1'b1, 2'd1);

    // Reader of $0 behind it: no hazard.
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd4, 32'd0, 12'h004, 1'b0, 32'd13, 32'd14);
    expect_d(1'b0, 1'b1, 1'b0, 2'd1, 32'd13, 32'd14, 5'd4, 5'd0, 5'd0, 32'd0, 12'h004);

    // Load to $7.
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd7, 32'd0, 12'h005, 1'b1, 32'd0, 32'd0);
    expect_c(1'b0, 1'b1, 1'b1, 2'd1);

    // Flush beats ext_stall and the hazard; counter untouched.
    @(negedge clk);
    ctl(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd7, 5'd3, 5'd8, 32'd1, 12'h006, 1'b0, 32'd21, 32'd22);
    expect_c(1'b1, 1'b0, 1'b0, 2'd1);

    // Back in RUN with an empty EX slot: capture.
    @(negedge clk);
    ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    expect_d(1'b0, 1'b1, 1'b0, 2'd1, 32'd21, 32'd22, 5'd8, 5'd7, 5'd3, 32'd1, 12'h006);

    // Capture an instruction reading $20/$21.
    @(negedge clk);
    drive(1'b1, 5'd20, 5'd21, 5'd9, 32'd6, 12'h007, 1'b0, 32'd30, 32'd31);
    expect_d(1'b0, 1'b1, 1'b0, 2'd1, 32'd30, 32'd31, 5'd9, 5'd20, 5'd21, 32'd6, 12'h007);

    // Downstream stall while $21 is written back.
    @(negedge clk);
    ctl(1'b1, 1'b0, 1'b1, 5'd21, 32'd152);
    drive(1'b1, 5'd1, 5'd1, 5'd1, 32'd99, 12'h0FF, 1'b0, 32'd99, 32'd99);
    expect_d(1'b1, 1'b1, 1'b0, 2'd1, 32'd30, byp_held, 5'd9, 5'd20, 5'd21, 32'd6, 12'h007);

    // Capture with a writeback to the source register.
    @(negedge clk);
    ctl(1'b0, 1'b0, 1'b1, 5'd10, 32'd421);
    drive(1'b1, 5'd10, 5'd11, 5'd12, 32'd7, 12'h008, 1'b0, 32'd420, 32'd5);
    expect_d(1'b0, 1'b1, 1'b0, 2'd1, byp_cap, 32'd5, 5'd12, 5'd10, 5'd11, 32'd7, 12'h008);

    // Writeback to $0 is never forwarded.
    @(negedge clk);
    ctl(1'b0, 1'b0, 1'b1, 5'd0, 32'd421);
    drive(1'b1, 5'd0, 5'd11, 5'd12, 32'd8, 12'h009, 1'b0, 32'd420, 32'd6);
    expect_d(1'b0, 1'b1, 1'b0, 2'd1, 32'd420, 32'd6, 5'd12, 5'd0, 5'd11, 32'd8, 12'h009);

    // Matching address without write enable is not forwarded.
    @(negedge clk);
    ctl(1'b0, 1'b0, 1'b0, 5'd10, 32'd421);
    drive(1'b1, 5'd10, 5'd11, 5'd12, 32'd9, 12'h00A, 1'b0, 32'd50, 32'd6);
    expect_d(1'b0, 1'b1, 1'b0, 2'd1, 32'd50, 32'd6, 5'd12, 5'd10, 5'd11, 32'd9, 12'h00A);

    // Four more load-use pairs: 2-bit counter saturates at 3.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctl(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      drive(1'b1, 5'd1, 5'd1, 5'd2, 32'd0, 12'h010, 1'b1, 32'd1, 32'd1);
      expect_c(1'b0, 1'b1, 1'b1, (i == 0) ? 2'd1 : cnt_tab[i-1]);
      @(negedge clk);
      drive(1'b1, 5'd2, 5'd3, 5'd4, 32'd0, 12'h011, 1'b0, 32'd2, 32'd3);
      expect_c(1'b1, 1'b0, 1'b0, cnt_tab[i]);
      @(negedge clk);
      expect_c(1'b0, 1'b1, 1'b0, cnt_tab[i]);
    end

    // Invalid slot carrying a load flag captures as a clean bubble.
    @(negedge clk);
    drive(1'b0, 5'd4, 5'd4, 5'd5, 32'd0, 12'h012, 1'b1, 32'd0, 32'd0);
    expect_c(1'b0, 1'b0, 1'b0, 2'd3);

    @(negedge clk);
    @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
